// File: rtl/ifetch_prefetch_queue.sv
// Instruction-fetch prefetch queue: issues in-order fetches to a variable-latency
// imem and buffers returned words with their PCs in a first-word-fall-through queue.
module ifetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [15:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [15:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        inst_valid,
    output logic [15:0] inst_data,
    output logic [15:0] inst_pc,
    input  logic        inst_ready,
    output logic        err_unexp_rsp
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   mem_data [DEPTH];
    logic [15:0]   mem_pc   [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [15:0]   fetch_pc;
    logic [15:0]   rsp_pc;
    logic          run;
    logic          err;
    logic [CW+1:0] credit_sum;
    logic          accept;
    logic          rsp_drop;
    logic          rsp_push;
    logic          rsp_unexp;
    logic          push;
    logic          pop;

    // Every word buffered, in flight or awaiting discard holds one credit.
    assign credit_sum = {2'b00, count} + {2'b00, outstanding} + {2'b00, discard};

    assign imem_req_valid = run & ~redirect & (credit_sum < (CW+2)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid & imem_req_ready;

    assign rsp_drop  = imem_rsp_valid & (discard != '0);
    assign rsp_push  = imem_rsp_valid & (discard == '0) & (outstanding != '0);
    assign rsp_unexp = imem_rsp_valid & (discard == '0) & (outstanding == '0);

    assign push = rsp_push & ~redirect;
    assign pop  = inst_valid & inst_ready & ~redirect;

    assign inst_valid    = (count != '0);
    assign inst_data     = inst_valid ? mem_data[rd_ptr] : 16'h0;
    assign inst_pc       = inst_valid ? mem_pc[rd_ptr] : 16'h0;
    assign err_unexp_rsp = err;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= imem_rsp_data;
            mem_pc[wr_ptr]   <= rsp_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            err         <= 1'b0;
        end else begin
            run <= 1'b1;
            if (rsp_unexp) err <= 1'b1;
            if (redirect) begin
                fetch_pc    <= redirect_pc;
                rsp_pc      <= redirect_pc;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                count       <= '0;
                outstanding <= '0;
                // In-flight words become stale; one arriving now is dropped.
                discard     <= discard + outstanding
                             - CW'(imem_rsp_valid & ~rsp_unexp);
            end else begin
                if (accept) fetch_pc <= fetch_pc + 16'd1;
                if (push) begin
                    rsp_pc <= rsp_pc + 16'd1;
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count       <= count + CW'(push) - CW'(pop);
                outstanding <= outstanding + CW'(accept) - CW'(rsp_push);
                discard     <= discard - CW'(rsp_drop);
            end
        end
    end

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Scoreboard bench for ifetch_prefetch_queue: imem model with programmable
// latency, expected words queued at request acceptance, checked at each pop.
module tb_ifetch_prefetch_queue;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        inst_valid;
    logic [15:0] inst_data;
    logic [15:0] inst_pc;
    logic        inst_ready;
    logic        err_unexp_rsp;

    ifetch_prefetch_queue #(.DEPTH(4), .RESET_PC(16'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .err_unexp_rsp  (err_unexp_rsp)
    );

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } pend_t;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          n_acc    = 0;
    int          n_pop    = 0;
    logic [15:0] exp_pc   = 16'h0;
    bit          inject   = 1'b0;
    logic        rdr_rsp  = 1'b0;
    logic        rdr_pop  = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Monitor: samples one time unit before each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            if (!rst_n) begin
                exp_q.delete();
                exp_pc = 16'h0;
            end else if (redirect) begin
                check("req_valid_in_redirect", {31'b0, imem_req_valid}, 32'd0);
                rdr_rsp = imem_rsp_valid;
                rdr_pop = inst_valid & inst_ready;
                exp_q.delete();
                exp_pc = redirect_pc;
            end else begin
                if (inst_valid && inst_ready) begin
                    n_pop++;
                    check("pop_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("inst_pc", {16'b0, inst_pc}, {16'b0, e.pc});
                        check("inst_data", {16'b0, inst_data}, {16'b0, e.data});
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    n_acc++;
                    check("req_addr", {16'b0, imem_req_addr}, {16'b0, exp_pc});
                    exp_q.push_back({exp_pc, exp_pc ^ 16'hA5A5});
                    exp_pc = exp_pc + 16'd1;
                end
            end
            if (rst_n && imem_req_valid && imem_req_ready)
                pend_q.push_back('{imem_req_addr, cyc + lat - 1});
        end
    end

    // Instruction memory model: in-order responses after lat cycles.
    initial begin
        pend_t p;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 16'h0;
        forever begin
            @(negedge clk);
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 16'h0;
            if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
                p = pend_q.pop_front();
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = p.addr ^ 16'hA5A5;
            end else if (inject) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 16'hDEAD;
                inject = 1'b0;
            end
        end
    end

    task automatic do_redirect(input logic [15:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        @(negedge clk);
        redirect    = 1'b0;
    endtask

    initial begin
        int a0;
        int p0;
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = 16'h0;
        inst_ready     = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst_data", {16'b0, inst_data}, 32'd0);
        check("rst_inst_pc", {16'b0, inst_pc}, 32'd0);
        check("rst_err", {31'b0, err_unexp_rsp}, 32'd0);

        // Stalled consumer: credits cap the accepted requests.
        rst_n = 1'b1;
        a0 = n_acc;
        repeat (20) @(negedge clk);
        check("stall_accepts", n_acc - a0, 32'd4);
        check("stall_inst_valid", {31'b0, inst_valid}, 32'd1);
        check("stall_inst_pc", {16'b0, inst_pc}, 32'd0);
        check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);

        // Streaming at one word per cycle.
        inst_ready = 1'b1;
        p0 = n_pop;
        repeat (30) @(negedge clk);
        check("stream_pops", {31'b0, (n_pop - p0) >= 25}, 32'd1);

        // Redirect coincident with a response and a pop.
        do_redirect(16'h1234);
        check("redirect_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("redirect_saw_rsp", {31'b0, rdr_rsp}, 32'd1);
        check("redirect_saw_pop", {31'b0, rdr_pop}, 32'd1);
        p0 = n_pop;
        repeat (20) @(negedge clk);
        check("post_redirect_pops", {31'b0, (n_pop - p0) >= 10}, 32'd1);
        check("post_redirect_err", {31'b0, err_unexp_rsp}, 32'd0);

        // Latency 3, redirect with exactly two requests in flight.
        lat = 3;
        imem_req_ready = 1'b0;
        repeat (10) @(negedge clk);
        a0 = n_acc;
        imem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        imem_req_ready = 1'b0;
        check("inflight_accepts", n_acc - a0, 32'd2);
        do_redirect(16'h0040);
        imem_req_ready = 1'b1;
        p0 = n_pop;
        repeat (25) @(negedge clk);
        check("lat3_pops", {31'b0, (n_pop - p0) >= 8}, 32'd1);
        check("lat3_err", {31'b0, err_unexp_rsp}, 32'd0);

        // PC wrap across 16'hFFFF.
        lat = 1;
        repeat (6) @(negedge clk);
        do_redirect(16'hFFFE);
        p0 = n_pop;
        repeat (20) @(negedge clk);
        check("wrap_pops", {31'b0, (n_pop - p0) >= 10}, 32'd1);

        // Unexpected response sets a sticky error.
        imem_req_ready = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_inject_err", {31'b0, err_unexp_rsp}, 32'd0);
        inject = 1'b1;
        repeat (3) @(negedge clk);
        check("inject_err", {31'b0, err_unexp_rsp}, 32'd1);
        imem_req_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("sticky_err", {31'b0, err_unexp_rsp}, 32'd1);

        // Asynchronous reset mid-stream.
        rst_n = 1'b0;
        #1;
        check("arst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("arst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("arst_inst_data", {16'b0, inst_data}, 32'd0);
        check("arst_inst_pc", {16'b0, inst_pc}, 32'd0);
        check("arst_err", {31'b0, err_unexp_rsp}, 32'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        p0 = n_pop;
        repeat (20) @(negedge clk);
        check("restart_pops", {31'b0, (n_pop - p0) >= 10}, 32'd1);
        check("restart_err", {31'b0, err_unexp_rsp}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
